// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the RV32I MEM stage: FSM states, load/store
// func3 codes and a legality helper used by the alignment logic.
package stage_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Data-memory request/grant/response bus between the MEM stage and data memory.
interface stage_mem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/stage_mem_align.sv
// Combinational lane logic: byte enables and replicated store data, load
// extraction with sign/zero extension, and the misaligned/illegal flag.
module mem_align
    import stage_mem_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        bad_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = rdata_i >> {addr_lo_i, 3'b000};
        byte_val = shifted[7:0];
        half_val = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        be_o    = 4'b1111;
        wdata_o = store_data_i;
        if (is_store_i) begin
            case (func3_i[1:0])
                2'b00: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: ;
            endcase
        end

        case (func3_i)
            F3_LB:   load_data_o = {{24{byte_val[7]}}, byte_val};
            F3_LH:   load_data_o = {{16{half_val[15]}}, half_val};
            F3_LW:   load_data_o = rdata_i;
            F3_LBU:  load_data_o = {24'h0, byte_val};
            F3_LHU:  load_data_o = {16'h0, half_val};
            default: load_data_o = 32'h0;
        endcase

        // func3[1:0] encodes the access width for every legal load and store
        bad_o = !f3_legal(is_store_i, func3_i) ||
                ((func3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                ((func3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    end

endmodule

// File: rtl/stage_mem.sv
// RV32I MEM stage: drives the data-memory handshake, stalls the pipeline
// while an access is outstanding and formats load results for MEM/WB.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        me_valid,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic [2:0]  me_func3_code,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_regs_data2,
    stage_mem_if.master dmem,
    output logic        me_stall,
    output logic [31:0] me_load_data,
    output logic        me_misalign,
    output logic        me_bus_err
);

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;
    logic [31:0] load_q, load_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        start;
    logic        is_store_live;
    logic        in_idle;
    logic        timeout;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic        al_store;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_bad;

    assign start         = me_valid && (me_mem_read || me_mem_write);
    assign is_store_live = me_mem_write && !me_mem_read;
    assign in_idle       = (state_q == ST_IDLE);
    assign timeout       = (cnt_q >= CNT_W'(WAIT_MAX - 1));

    // Live fields decide legality at start; registered ones format the response
    assign al_f3    = in_idle ? me_func3_code : f3_q;
    assign al_off   = in_idle ? me_alu_o[1:0] : off_q;
    assign al_store = in_idle ? is_store_live : store_q;

    mem_align u_align (
        .func3_i      (al_f3),
        .addr_lo_i    (al_off),
        .is_store_i   (al_store),
        .store_data_i (me_regs_data2),
        .rdata_i      (dmem.dmem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load),
        .bad_o        (al_bad)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        off_d      = off_q;
        f3_d       = f3_q;
        store_d    = store_q;
        load_d     = 32'h0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    f3_d    = me_func3_code;
                    off_d   = me_alu_o[1:0];
                    store_d = is_store_live;
                    if (al_bad) begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store_live;
                        addr_d  = {me_alu_o[31:2], 2'b00};
                        wdata_d = al_wdata;
                        be_d    = al_be;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt) begin
                    req_d = 1'b0;
                    if (store_q) begin
                        state_d = ST_DONE;
                    end else if (dmem.dmem_rvalid) begin
                        load_d  = al_load;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_RESP;
                    end
                end else if (timeout) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (dmem.dmem_rvalid) begin
                    load_d  = al_load;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            store_q    <= 1'b0;
            load_q     <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            store_q    <= store_d;
            load_q     <= load_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Stall is held low while reset is asserted even if EX presents a load
    assign me_stall = rstn && ((in_idle && start) ||
                               (state_q == ST_REQ) || (state_q == ST_RESP));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
    assign me_load_data    = load_q;
    assign me_misalign     = misalign_q;
    assign me_bus_err      = bus_err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem with a scripted data-memory responder.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        meValid, meRead, meWrite;
    logic [2:0]  meFunc3;
    logic [31:0] meAddr, meData;
    logic        meStall;
    logic [31:0] meLoadData;
    logic        meMisalign, meBusErr;

    int total = 0;
    int bad = 0;

    int          stallCnt, reqCnt;
    logic [31:0] seenAddr, seenWdata, doneData;
    logic [3:0]  seenBe;
    logic        seenWe, doneMis, doneErr, doneSeen;

    always #5 clk = ~clk;

    stage_mem_if dmemIf ();

    stage_mem #(.WAIT_MAX(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .me_valid      (meValid),
        .me_mem_read   (meRead),
        .me_mem_write  (meWrite),
        .me_func3_code (meFunc3),
        .me_alu_o      (meAddr),
        .me_regs_data2 (meData),
        .dmem          (dmemIf),
        .me_stall      (meStall),
        .me_load_data  (meLoadData),
        .me_misalign   (meMisalign),
        .me_bus_err    (meBusErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one access from its start cycle to DONE; gntAt/rvAt count cycles after start (0 = never)
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input int gntAt, input int rvAt, input logic [31:0] rdata);
        meValid = 1'b1; meRead = rd; meWrite = wr; meFunc3 = f3; meAddr = addr; meData = sdata;
        dmemIf.dmem_rdata = rdata;
        stallCnt = 0; reqCnt = 0; doneSeen = 1'b0;
        seenAddr = 32'h0; seenWdata = 32'h0; seenBe = 4'h0; seenWe = 1'b0;
        doneData = 32'h0; doneMis = 1'b0; doneErr = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            dmemIf.dmem_gnt    = (gntAt != 0) && (cyc == gntAt);
            dmemIf.dmem_rvalid = (rvAt != 0) && (cyc == rvAt);
            #1;
            if (!meStall) begin
                doneSeen = 1'b1;
                doneData = meLoadData;
                doneMis  = meMisalign;
                doneErr  = meBusErr;
                break;
            end
            stallCnt++;
            if (dmemIf.dmem_req) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    seenAddr = dmemIf.dmem_addr; seenWdata = dmemIf.dmem_wdata;
                    seenBe = dmemIf.dmem_be; seenWe = dmemIf.dmem_we;
                end
            end
            @(posedge clk); #1;
        end
        dmemIf.dmem_gnt = 1'b0; dmemIf.dmem_rvalid = 1'b0;
        meValid = 1'b0; meRead = 1'b0; meWrite = 1'b0;
        if (!doneSeen) checkOutput("done_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        meValid = 0; meRead = 0; meWrite = 0; meFunc3 = 0; meAddr = 0; meData = 0;
        dmemIf.dmem_gnt = 0; dmemIf.dmem_rvalid = 0; dmemIf.dmem_rdata = 0;

        #12;
        checkOutput("rst_req",   dmemIf.dmem_req, 0);
        checkOutput("rst_be",    dmemIf.dmem_be, 0);
        checkOutput("rst_stall", meStall, 0);
        checkOutput("rst_load",  meLoadData, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0, 1, F3_SW, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0);
        checkOutput("sw_addr",  seenAddr, 32'h100);
        checkOutput("sw_be",    seenBe, 4'b1111);
        checkOutput("sw_we",    seenWe, 1);
        checkOutput("sw_wdata", seenWdata, 32'hDEADBEEF);
        checkOutput("sw_stall", stallCnt, 3);
        checkOutput("sw_flags", {doneMis, doneErr}, 0);

        applyStimulus(1, 0, F3_LB, 32'h203, 32'h0, 1, 1, 32'h80FF1234);
        checkOutput("lb_addr",  seenAddr, 32'h200);
        checkOutput("lb_we",    seenWe, 0);
        checkOutput("lb_be",    seenBe, 4'b1111);
        checkOutput("lb_data",  doneData, 32'hFFFFFF80);
        checkOutput("lb_clear", meLoadData, 0);

        applyStimulus(1, 0, F3_LBU, 32'h203, 32'h0, 1, 1, 32'h80FF1234);
        checkOutput("lbu_data", doneData, 32'h00000080);

        applyStimulus(0, 1, F3_SH, 32'h302, 32'h0000ABCD, 1, 0, 32'h0);
        checkOutput("sh_be",    seenBe, 4'b1100);
        checkOutput("sh_wdata", seenWdata, 32'hABCDABCD);
        checkOutput("sh_addr",  seenAddr, 32'h300);

        applyStimulus(0, 1, F3_SB, 32'h101, 32'h000000A5, 1, 0, 32'h0);
        checkOutput("sb_be",    seenBe, 4'b0010);
        checkOutput("sb_wdata", seenWdata, 32'hA5A5A5A5);

        applyStimulus(1, 0, F3_LH, 32'h301, 32'h0, 1, 1, 32'h0);
        checkOutput("lhmis_req",   reqCnt, 0);
        checkOutput("lhmis_flag",  doneMis, 1);
        checkOutput("lhmis_stall", stallCnt, 1);
        checkOutput("lhmis_data",  doneData, 0);
        checkOutput("lhmis_clear", meMisalign, 0);

        applyStimulus(1, 0, 3'b011, 32'h400, 32'h0, 1, 1, 32'h0);
        checkOutput("ldill_flag", doneMis, 1);
        checkOutput("ldill_req",  reqCnt, 0);

        applyStimulus(0, 1, 3'b100, 32'h400, 32'h0, 1, 0, 32'h0);
        checkOutput("still_flag", doneMis, 1);

        applyStimulus(1, 1, F3_LW, 32'h404, 32'h0, 1, 1, 32'h12345678);
        checkOutput("lw_we",    seenWe, 0);
        checkOutput("lw_data",  doneData, 32'h12345678);
        checkOutput("lw_stall", stallCnt, 2);

        applyStimulus(1, 0, F3_LH, 32'h202, 32'h0, 1, 3, 32'h80FF1234);
        checkOutput("lh_data",  doneData, 32'hFFFF80FF);
        checkOutput("lh_stall", stallCnt, 4);

        applyStimulus(1, 0, F3_LHU, 32'h200, 32'h0, 1, 2, 32'hF0F08001);
        checkOutput("lhu_data", doneData, 32'h00008001);

        applyStimulus(1, 0, F3_LW, 32'h600, 32'h0, 0, 0, 32'hCAFEF00D);
        checkOutput("to_req",   reqCnt, 16);
        checkOutput("to_err",   doneErr, 1);
        checkOutput("to_data",  doneData, 0);
        checkOutput("to_stall", stallCnt, 17);
        dmemIf.dmem_rvalid = 1'b1;
        #1;
        checkOutput("late_req",   dmemIf.dmem_req, 0);
        checkOutput("late_stall", meStall, 0);
        @(posedge clk); #1;
        dmemIf.dmem_rvalid = 1'b0;
        checkOutput("late_load", meLoadData, 0);
        checkOutput("late_err",  meBusErr, 0);

        meValid = 1; meRead = 1; meWrite = 0; meFunc3 = F3_LW; meAddr = 32'h500;
        @(posedge clk); #1;
        dmemIf.dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmemIf.dmem_gnt = 1'b0;
        #1;
        checkOutput("resp_stall", meStall, 1);
        rstn = 1'b0;
        #1;
        checkOutput("arst_stall", meStall, 0);
        checkOutput("arst_req",   dmemIf.dmem_req, 0);
        checkOutput("arst_addr",  dmemIf.dmem_addr, 0);
        checkOutput("arst_be",    dmemIf.dmem_be, 0);
        checkOutput("arst_flags", {meMisalign, meBusErr}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        meValid = 1; meRead = 0; meWrite = 0; meFunc3 = 3'b000; meAddr = 32'h7;
        #1;
        checkOutput("add_stall", meStall, 0);
        @(posedge clk); #1;
        checkOutput("add_stall2", meStall, 0);
        checkOutput("add_req",    dmemIf.dmem_req, 0);
        meValid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
